// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle between the EX stage and alu_mc
interface alu_mc_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    ALUResult;
   logic                     busy;
   modport master (
      output in_valid, SrcA, SrcB, Operation, out_ready,
      input  in_ready, out_valid, ALUResult, busy
   );
   modport slave (
      input  in_valid, SrcA, SrcB, Operation, out_ready,
      output in_ready, out_valid, ALUResult, busy
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RISC-V EX-stage ALU (integer ops, MUL/MULH, restoring DIV/REM) with valid/ready handshake
module alu_mc #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input logic     clk,
   input logic     reset,
   input logic     flush,
   alu_mc_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int SW = $clog2(W);
   typedef logic [OPCODE_LENGTH-1:0] op_t;
   localparam op_t OP_AND  = op_t'(0);
   localparam op_t OP_SUB  = op_t'(1);
   localparam op_t OP_ADD  = op_t'(2);
   localparam op_t OP_NE   = op_t'(3);
   localparam op_t OP_OR   = op_t'(4);
   localparam op_t OP_XOR  = op_t'(5);
   localparam op_t OP_SLT  = op_t'(6);
   localparam op_t OP_SLTU = op_t'(7);
   localparam op_t OP_EQ   = op_t'(8);
   localparam op_t OP_SLL  = op_t'(9);
   localparam op_t OP_SRL  = op_t'(10);
   localparam op_t OP_SRA  = op_t'(11);
   localparam op_t OP_MUL  = op_t'(12);
   localparam op_t OP_MULH = op_t'(13);
   localparam op_t OP_DIV  = op_t'(14);
   localparam op_t OP_REM  = op_t'(15);
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [SW-1:0]  cnt_q, cnt_d;
   logic           negq_q, negq_d, negr_q, negr_d;
   logic [W-1:0]   sa, sb, simple, special_res, quo_n, rem_n, div_res;
   logic [SW-1:0]  sh;
   logic [2*W-1:0] full;
   logic [W:0]     trial, diff;
   logic           is_mul, is_div, div_zero, div_ovf;
   always_comb begin
      sa = bus.SrcA;
      sb = bus.SrcB;
      sh = sb[SW-1:0];
      case (bus.Operation)
         OP_AND:  simple = sa & sb;
         OP_SUB:  simple = sa - sb;
         OP_ADD:  simple = sa + sb;
         OP_NE:   simple = W'(sa != sb);
         OP_OR:   simple = sa | sb;
         OP_XOR:  simple = sa ^ sb;
         OP_SLT:  simple = W'($signed(sa) < $signed(sb));
         OP_SLTU: simple = W'(sa < sb);
         OP_EQ:   simple = W'(sa == sb);
         OP_SLL:  simple = sa << sh;
         OP_SRL:  simple = sa >> sh;
         OP_SRA:  simple = W'($signed(sa) >>> sh);
         default: simple = '0;
      endcase
      is_mul = bus.Operation == OP_MUL || bus.Operation == OP_MULH;
      is_div = bus.Operation == OP_DIV || bus.Operation == OP_REM;
      div_zero = sb == '0;
      div_ovf = sa == MIN && sb == '1;
      special_res = (bus.Operation == OP_DIV) ? (div_zero ? '1 : sa) : (div_zero ? sa : '0);
      full = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
      // one restoring step: shift in the next dividend bit, subtract if it fits
      trial = {rem_q, quo_q[W-1]};
      diff = trial - {1'b0, dvs_q};
      rem_n = diff[W] ? trial[W-1:0] : diff[W-1:0];
      quo_n = {quo_q[W-2:0], ~diff[W]};
      div_res = (op_q == OP_DIV) ? (negq_q ? -quo_n : quo_n) : (negr_q ? -rem_n : rem_n);
   end
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      a_d = a_q;
      b_d = b_q;
      res_d = res_q;
      prod_d = prod_q;
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (flush) begin
         state_d = IDLE;
         res_d = '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               op_d = bus.Operation;
               a_d = sa;
               b_d = sb;
               rem_d = '0;
               quo_d = sa[W-1] ? -sa : sa;
               dvs_d = sb[W-1] ? -sb : sb;
               cnt_d = '0;
               negq_d = sa[W-1] ^ sb[W-1];
               negr_d = sa[W-1];
               state_d = is_mul ? MUL : (is_div && !div_zero && !div_ovf) ? DIV : DONE;
               res_d = is_div ? special_res : simple;
            end
            MUL: begin
               prod_d = full;
               state_d = DONE;
            end
            DIV: begin
               rem_d = rem_n;
               quo_d = quo_n;
               cnt_d = cnt_q + SW'(1);
               if (cnt_q == SW'(W - 1)) begin
                  res_d = div_res;
                  state_d = DONE;
               end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         prod_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         a_q <= a_d;
         b_q <= b_d;
         res_q <= res_d;
         prod_q <= prod_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end
   assign bus.in_ready = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy = state_q == MUL || state_q == DIV;
   assign bus.ALUResult = (op_q == OP_MUL) ? prod_q[W-1:0] : (op_q == OP_MULH) ? prod_q[2*W-1:W] : res_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        seen;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_res = '0;
   alu_mc_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();
   alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask
   function automatic logic special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return op >= 4'hE && (b == 32'h0 || (a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint p;
      logic [4:0] sh;
      sa = a;
      sb = b;
      sh = b[4:0];
      p = longint'(sa) * longint'(sb);
      case (op)
         4'h0: return a & b;
         4'h1: return a - b;
         4'h2: return a + b;
         4'h3: return {31'b0, a != b};
         4'h4: return a | b;
         4'h5: return a ^ b;
         4'h6: return {31'b0, sa < sb};
         4'h7: return {31'b0, a < b};
         4'h8: return {31'b0, a == b};
         4'h9: return a << sh;
         4'hA: return a >> sh;
         4'hB: return 32'(sa >>> sh);
         4'hC: return p[31:0];
         4'hD: return p[63:32];
         4'hE: return (b == 0) ? 32'hFFFFFFFF : special(op, a, b) ? a : 32'(sa / sb);
         default: return (b == 0) ? a : special(op, a, b) ? 32'h0 : 32'(sa % sb);
      endcase
   endfunction
   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return (op < 4'hC || special(op, a, b)) ? 1 : (op < 4'hE) ? 2 : 33;
   endfunction
   function automatic int exp_busy(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return (op < 4'hC || special(op, a, b)) ? 0 : (op < 4'hE) ? 1 : 32;
   endfunction
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         check("result", bus.ALUResult, exp_res);
         check("busy_with_valid", 32'(bus.busy), 32'h0);
         check("in_ready_with_valid", 32'(bus.in_ready), 32'h0);
      end
   end
   task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check("in_ready_idle", 32'(bus.in_ready), 32'h1);
      bus.in_valid = 1'b1;
      bus.Operation = op;
      bus.SrcA = a;
      bus.SrcB = b;
      exp_res = model(op, a, b);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.Operation = ~op;
      bus.SrcA = ~a;
      bus.SrcB = ~b;
   endtask
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int stall);
      int n = 1;
      int nb = 0;
      check($sformatf("model op%h", op), model(op, a, b), lit);
      accept(op, a, b);
      while (!bus.out_valid && n < 100) begin
         nb += int'(bus.busy);
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("latency op%h", op), n, exp_lat(op, a, b));
      check($sformatf("busy_cycles op%h", op), nb, exp_busy(op, a, b));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         bus.SrcA = $urandom;
         @(posedge clk);
         #1;
         check("hold_valid", 32'(bus.out_valid), 32'h1);
         check("hold_in_ready", 32'(bus.in_ready), 32'h0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("release_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.SrcA = '0;
      bus.SrcB = '0;
      bus.Operation = '0;
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_result", bus.ALUResult, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      run_op(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0);
      run_op(4'hB, 32'h80000000, 32'h00000021, 32'hC0000000, 5);
      run_op(4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0);
      run_op(4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
      run_op(4'h1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0);
      run_op(4'h3, 32'h00000005, 32'h00000005, 32'h00000000, 0);
      run_op(4'h4, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0);
      run_op(4'h5, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 0);
      run_op(4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0);
      run_op(4'h8, 32'h00001234, 32'h00001234, 32'h00000001, 0);
      run_op(4'h9, 32'h00000001, 32'h0000003F, 32'h80000000, 0);
      run_op(4'hA, 32'h80000000, 32'h00000004, 32'h08000000, 0);
      run_op(4'hD, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0);
      run_op(4'hC, 32'h00010000, 32'h00010000, 32'h00000000, 3);
      run_op(4'hD, 32'h80000000, 32'h80000000, 32'h40000000, 0);
      run_op(4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0);
      run_op(4'hF, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5);
      run_op(4'hE, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 0);
      run_op(4'hF, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 0);
      run_op(4'hE, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
      run_op(4'hF, 32'h00000005, 32'h00000000, 32'h00000005, 0);
      run_op(4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
      run_op(4'hF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
      accept(4'hE, 32'hFFFFFFF9, 32'h00000002);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_in_ready", 32'(bus.in_ready), 32'h1);
      check("flush_busy", 32'(bus.busy), 32'h0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= bus.out_valid;
      end
      check("flush_no_valid", 32'(seen), 32'h0);
      @(negedge clk);
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.Operation = 4'h2;
      bus.SrcA = 32'h1;
      bus.SrcB = 32'h1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_ignores_in_valid", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
      run_op(4'h2, 32'h00000002, 32'h00000003, 32'h00000005, 0);
      accept(4'hE, 32'h00000064, 32'h00000007);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("areset_in_ready", 32'(bus.in_ready), 32'h1);
      check("areset_out_valid", 32'(bus.out_valid), 32'h0);
      check("areset_busy", 32'(bus.busy), 32'h0);
      check("areset_result", bus.ALUResult, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      run_op(4'hF, 32'h00000064, 32'h00000007, 32'h00000002, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V pipeline EX stage. It extends the single-cycle integer ALU with shifts, set-less-than, RV32M multiply/divide and a valid/ready handshake. The hazard unit uses `busy` to stall IF/ID/EX while a multiply or divide is in flight. Results are registered and held until the consumer accepts them.

## Interface
- `DATA_WIDTH`, 32, operand/result width (even, ≥8)
- `OPCODE_LENGTH`, 4, width of `Operation`
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state
- `flush`  input  1  synchronous abort of any operation in flight or held
- `in_valid`  input  1  `SrcA`/`SrcB`/`Operation` valid this cycle
- `in_ready`  output  1  block can accept an operation
- `SrcA`, `SrcB`  input  DATA_WIDTH  operands
- `Operation`  input  OPCODE_LENGTH  operation select
- `out_valid`  output  1  `ALUResult` valid
- `out_ready`  input  1  consumer takes the result this cycle
- `ALUResult`  output  DATA_WIDTH  registered result
- `busy`  output  1  state is MUL or DIV

## Operation
- Opcodes:
  - 0000 AND; 0001 SUB; 0010 ADD (both signed, wrap mod 2^W)
  - 0011 NE (1 if A≠B); 0100 OR; 0101 XOR
  - 0110 SLT (signed, result 1/0); 0111 SLTU
  - 1000 EQ (1 if A==B)
  - 1001 SLL; 1010 SRL; 1011 SRA; shift amount = `SrcB[$clog2(W)-1:0]`, upper bits ignored
  - 1100 MUL (low W bits of product); 1101 MULH (high W bits, signed×signed)
  - 1110 DIV (signed quotient, toward zero); 1111 REM (signed, sign of dividend)
- Divide special cases, per RISC-V:
  - B==0: DIV returns all-ones; REM returns A.
  - A==−2^(W−1) and B==−1: DIV returns A; REM returns 0.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE: `in_ready`=1. Accept on `in_valid`.
    - Opcodes 0000–1011 → DONE.
    - 1100/1101 → MUL.
    - 1110/1111 with a special case → DONE.
    - Other 1110/1111 → DIV.
  - MUL: one cycle; registers the full 2W signed product, then → DONE.
  - DIV: restoring divider on operand magnitudes, one quotient bit per cycle, W cycles. Signs are fixed on the final iteration. Then → DONE.
  - DONE: `out_valid`=1, `ALUResult` stable. When `out_ready`=1 → IDLE.
- `in_ready` is 1 only in IDLE. No new operation is accepted in DONE, even when `out_ready`=1.
- Operands and opcode are captured at acceptance. Input changes afterwards have no effect.
- Undefined opcode: none exist at OPCODE_LENGTH=4. For wider opcodes, unused codes complete in 1 cycle with result 0.
- `flush`=1 in any state → IDLE on the next edge. `out_valid` drops, the result is discarded, and `in_valid` that same cycle is ignored.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `ALUResult`=0, `busy`=0. Divider/multiplier registers are cleared.
- Reset asserted mid-divide aborts immediately. The first operation after deassertion behaves as if from power-up.

## Timing
Edge k is the acceptance edge: `in_valid`&&`in_ready` sampled high.
- Opcodes 0000–1011 and divide special cases: `out_valid`=1 after edge k+1.
- MUL/MULH: `out_valid` after edge k+2.
- DIV/REM (general): `busy` high after edges k+1..k+W; `out_valid` after edge k+W+1 (k+33 at W=32).
- `out_valid` holds for as many cycles as `out_ready`=0. `ALUResult` does not change while `out_valid`=1.
- Back-to-back throughput is 1 operation per 2 cycles when `out_ready` is tied high.
- `busy` is never high in the same cycle as `out_valid`.

## Test plan
- Simple op: ADD A=0x7FFFFFFF, B=1 → 0x80000000 one cycle after accept. SRA A=0x80000000, B=0x21 (shamt 1) → 0xC0000000. SLTU A=1, B=0xFFFFFFFF → 1.
- Multiply: MULH A=0xFFFFFFFF (−1), B=0x00000002 → 0xFFFFFFFF after 2 cycles. MUL A=0x10000, B=0x10000 → 0.
- Divide: DIV A=−7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. `busy` high for exactly 32 cycles; `out_valid` 33 cycles after accept.
- Divide special cases: DIV A=5, B=0 → 0xFFFFFFFF; REM A=5, B=0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. All three complete 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result while toggling `SrcA`. Required: `ALUResult` stable, `in_ready`=0, then IDLE one cycle after `out_ready`=1.
- Abort:
  - `flush` in cycle 10 of a divide → IDLE next edge, `out_valid` never asserts; the next ADD 2+3 → 5.
  - `reset` pulse mid-divide → all outputs at reset values asynchronously.
